// File: rtl/calc2_req_master.sv
// calc2_req_master: issues two-beat calc2 requests for upstream ops and
// returns tagged calc2 responses through an in-order result FIFO.
module calc2_req_master #(
    parameter int TIMEOUT = 255
) (
    input  logic        c_clk,
    input  logic        reset,
    input  logic        op_valid,
    input  logic [3:0]  op_cmd,
    input  logic [31:0] op_data1,
    input  logic [31:0] op_data2,
    output logic        op_ready,
    output logic [1:0]  op_tag,
    output logic [3:0]  req_cmd_out,
    output logic [31:0] req_data_out,
    output logic [1:0]  req_tag_out,
    input  logic [1:0]  resp_in,
    input  logic [31:0] resp_data_in,
    input  logic [1:0]  resp_tag_in,
    output logic        res_valid,
    output logic [1:0]  res_resp,
    output logic [31:0] res_data,
    output logic [1:0]  res_tag,
    input  logic        res_ready,
    output logic        timeout_err,
    output logic        spurious_err
);

    localparam int WDW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SEND1 = 2'd1,
        S_SEND2 = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [3:0]  r_req_cmd;
    logic [31:0] r_req_data;
    logic [1:0]  r_req_tag;
    logic [3:0]  w_req_cmd_nxt;
    logic [31:0] w_req_data_nxt;
    logic [1:0]  w_req_tag_nxt;

    logic [1:0]  r_tag;
    logic [31:0] r_data2;

    logic [3:0]  r_alloc;
    logic [3:0]  r_pending;
    logic [1:0]  w_free_tag;
    logic        w_accept;

    logic        w_resp_vld;
    logic        w_push;
    logic        w_pop;
    logic        w_spur;
    logic [3:0]  w_alloc_set;
    logic [3:0]  w_alloc_clr;
    logic [3:0]  w_pend_clr;

    logic [35:0] r_mem [4];
    logic [1:0]  r_wr_ptr;
    logic [1:0]  r_rd_ptr;
    logic [2:0]  r_count;

    logic [WDW-1:0] r_wd;
    logic [WDW-1:0] w_wd_nxt;
    logic           r_timeout;
    logic           r_spur;

    // Lowest-index free tag; value is irrelevant when all tags are taken
    always_comb begin
        w_free_tag = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!r_alloc[i]) w_free_tag = 2'(i);
        end
    end

    assign op_ready = !reset && (r_state != S_SEND1) && (r_alloc != 4'hF);
    assign op_tag   = w_free_tag;
    assign w_accept = op_valid && op_ready;

    always_ff @(posedge c_clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_req_cmd  <= '0;
            r_req_data <= '0;
            r_req_tag  <= '0;
            r_tag      <= '0;
            r_data2    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_req_cmd  <= w_req_cmd_nxt;
            r_req_data <= w_req_data_nxt;
            r_req_tag  <= w_req_tag_nxt;
            if (w_accept) begin
                r_tag   <= w_free_tag;
                r_data2 <= op_data2;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_SEND1;
            S_SEND1: w_state_nxt = S_SEND2;
            S_SEND2: w_state_nxt = w_accept ? S_SEND1 : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Request beats are computed from the next state so req_* come from flops
    always_comb begin
        w_req_cmd_nxt  = '0;
        w_req_data_nxt = '0;
        w_req_tag_nxt  = '0;
        unique case (w_state_nxt)
            S_SEND1: begin
                w_req_cmd_nxt  = op_cmd;
                w_req_data_nxt = op_data1;
                w_req_tag_nxt  = w_free_tag;
            end
            S_SEND2: begin
                w_req_data_nxt = r_data2;
                w_req_tag_nxt  = r_tag;
            end
            default: ;
        endcase
    end

    assign req_cmd_out  = reset ? '0 : r_req_cmd;
    assign req_data_out = reset ? '0 : r_req_data;
    assign req_tag_out  = reset ? '0 : r_req_tag;

    assign w_resp_vld  = (resp_in != 2'd0);
    assign w_push      = w_resp_vld && r_pending[resp_tag_in];
    assign w_spur      = w_resp_vld && !r_pending[resp_tag_in];
    assign w_pop       = res_valid && res_ready;
    assign w_alloc_set = w_accept ? (4'b0001 << w_free_tag) : 4'b0000;
    assign w_alloc_clr = w_pop ? (4'b0001 << res_tag) : 4'b0000;
    assign w_pend_clr  = w_push ? (4'b0001 << resp_tag_in) : 4'b0000;

    always_ff @(posedge c_clk) begin
        if (reset) begin
            r_alloc   <= '0;
            r_pending <= '0;
        end else begin
            r_alloc   <= (r_alloc | w_alloc_set) & ~w_alloc_clr;
            r_pending <= (r_pending & ~w_pend_clr) | w_alloc_set;
        end
    end

    always_ff @(posedge c_clk) begin
        if (!reset && w_push) begin
            r_mem[r_wr_ptr] <= {resp_in, resp_data_in, resp_tag_in};
        end
    end

    // Depth 4 matches the tag space, so a push can never find the FIFO full
    always_ff @(posedge c_clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 2'd1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 2'd1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign res_valid = !reset && (r_count != 3'd0);
    assign {res_resp, res_data, res_tag} = r_mem[r_rd_ptr];

    always_comb begin
        w_wd_nxt = r_wd;
        if ((r_pending == 4'd0) || w_resp_vld) begin
            w_wd_nxt = '0;
        end else if (r_wd != WDW'(TIMEOUT)) begin
            w_wd_nxt = r_wd + WDW'(1);
        end
    end

    always_ff @(posedge c_clk) begin
        if (reset) begin
            r_wd      <= '0;
            r_timeout <= 1'b0;
            r_spur    <= 1'b0;
        end else begin
            r_wd <= w_wd_nxt;
            if (w_wd_nxt == WDW'(TIMEOUT)) r_timeout <= 1'b1;
            if (w_spur) r_spur <= 1'b1;
        end
    end

    assign timeout_err  = r_timeout;
    assign spurious_err = r_spur;

endmodule

// File: tb/tb_calc2_req_master.sv
// Bench for calc2_req_master: acts as upstream and as the calc2 device,
// with a queue scoreboard for requests and results.
module tb_calc2_req_master;

    localparam int TO = 8;

    logic        c_clk = 1'b0;
    logic        reset;
    logic        op_valid;
    logic [3:0]  op_cmd;
    logic [31:0] op_data1;
    logic [31:0] op_data2;
    logic        op_ready;
    logic [1:0]  op_tag;
    logic [3:0]  req_cmd_out;
    logic [31:0] req_data_out;
    logic [1:0]  req_tag_out;
    logic [1:0]  resp_in;
    logic [31:0] resp_data_in;
    logic [1:0]  resp_tag_in;
    logic        res_valid;
    logic [1:0]  res_resp;
    logic [31:0] res_data;
    logic [1:0]  res_tag;
    logic        res_ready;
    logic        timeout_err;
    logic        spurious_err;

    calc2_req_master #(.TIMEOUT(TO)) dut (
        .c_clk       (c_clk),
        .reset       (reset),
        .op_valid    (op_valid),
        .op_cmd      (op_cmd),
        .op_data1    (op_data1),
        .op_data2    (op_data2),
        .op_ready    (op_ready),
        .op_tag      (op_tag),
        .req_cmd_out (req_cmd_out),
        .req_data_out(req_data_out),
        .req_tag_out (req_tag_out),
        .resp_in     (resp_in),
        .resp_data_in(resp_data_in),
        .resp_tag_in (resp_tag_in),
        .res_valid   (res_valid),
        .res_resp    (res_resp),
        .res_data    (res_data),
        .res_tag     (res_tag),
        .res_ready   (res_ready),
        .timeout_err (timeout_err),
        .spurious_err(spurious_err)
    );

    always #5 c_clk = ~c_clk;

    typedef struct packed {
        logic [1:0]  resp;
        logic [31:0] data;
        logic [1:0]  tag;
    } res_t;

    typedef struct packed {
        logic [3:0]  cmd;
        logic [31:0] data;
        logic [1:0]  tag;
    } beat_t;

    res_t        exp_q[$];
    beat_t       req_q[$];
    logic [3:0]  m_alloc = '0;
    logic [3:0]  m_pending = '0;
    int          m_cnt = 0;
    logic        m_busy = 1'b0;
    logic        m_spur = 1'b0;
    logic [3:0]  m_cmd [4];
    logic [31:0] m_d1 [4];
    logic [31:0] m_d2 [4];
    int          n_chk = 0;
    int          n_pass = 0;
    time         t_acc [4];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t",
                      name, act, exp, $time);
    endtask

    function automatic logic [1:0] lowest_free(input logic [3:0] a);
        for (int i = 0; i < 4; i++) if (!a[i]) return 2'(i);
        return 2'd0;
    endfunction

    // The calc2 device this bench pretends to be
    function automatic logic [1:0] dev_code(input logic [3:0] c);
        if (c == 4'd0 || c > 4'd9) return 2'd2;
        return (c == 4'd9) ? 2'd3 : 2'd1;
    endfunction

    function automatic logic [31:0] dev_data(input logic [3:0] c,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
        case (c)
            4'd1:    return a + b;
            4'd2:    return a - b;
            4'd3:    return a & b;
            4'd4:    return a | b;
            default: return a ^ ~b;
        endcase
    endfunction

    // Monitor: compares outputs with the model, then advances the model
    always @(negedge c_clk) begin : mon
        beat_t      b;
        res_t       r;
        logic [1:0] t;
        logic       acc;
        logic       pop;
        if (reset) begin
            chk("rst_op_ready", op_ready, 1'b0);
            chk("rst_res_valid", res_valid, 1'b0);
            chk("rst_req", {req_cmd_out, req_data_out, req_tag_out}, 38'd0);
            m_alloc   = '0;
            m_pending = '0;
            m_cnt     = 0;
            m_busy    = 1'b0;
            m_spur    = 1'b0;
            req_q.delete();
            exp_q.delete();
        end else begin
            if (req_q.size() != 0) b = req_q.pop_front();
            else b = '0;
            chk("req_beat", {req_cmd_out, req_data_out, req_tag_out}, b);
            chk("op_ready", op_ready, (m_alloc != 4'hF) && !m_busy);
            chk("res_valid", res_valid, m_cnt != 0);
            chk("spurious_err", spurious_err, m_spur);
            acc = op_valid && op_ready;
            pop = res_valid && res_ready;
            t   = lowest_free(m_alloc);
            if (acc) begin
                chk("op_tag", op_tag, t);
                req_q.push_back({op_cmd, op_data1, t});
                req_q.push_back({4'h0, op_data2, t});
                m_cmd[t] = op_cmd;
                m_d1[t]  = op_data1;
                m_d2[t]  = op_data2;
            end
            if (pop) begin
                if (exp_q.size() == 0) begin
                    chk("res_unexpected_valid", res_valid, 1'b0);
                end else begin
                    r = exp_q.pop_front();
                    chk("res_entry", {res_resp, res_data, res_tag}, r);
                    m_alloc[r.tag] = 1'b0;
                end
                m_cnt--;
            end
            if (resp_in != 2'd0) begin
                if (m_pending[resp_tag_in]) begin
                    m_pending[resp_tag_in] = 1'b0;
                    m_cnt++;
                end else begin
                    m_spur = 1'b1;
                end
            end
            if (acc) begin
                m_alloc[t]   = 1'b1;
                m_pending[t] = 1'b1;
            end
            m_busy = acc;
        end
    end

    task automatic tick();
        @(posedge c_clk);
        #1;
    endtask

    task automatic do_op(input logic [3:0] c, input logic [31:0] a,
                         input logic [31:0] b);
        int n = 0;
        op_valid = 1'b1;
        op_cmd   = c;
        op_data1 = a;
        op_data2 = b;
        @(negedge c_clk);
        while (!op_ready && n < 50) begin
            @(negedge c_clk);
            n++;
        end
        if (!op_ready) chk("op_accept_wait", op_ready, 1'b1);
        tick();
        op_valid = 1'b0;
    endtask

    task automatic send_resp(input logic [1:0] tag, input logic [1:0] code,
                             input logic [31:0] data);
        resp_in      = code;
        resp_tag_in  = tag;
        resp_data_in = data;
        if (code != 2'd0 && m_pending[tag]) exp_q.push_back({code, data, tag});
        tick();
        resp_in      = 2'd0;
        resp_tag_in  = 2'($urandom);
        resp_data_in = $urandom;
    endtask

    task automatic respond(input logic [1:0] t);
        send_resp(t, dev_code(m_cmd[t]), dev_data(m_cmd[t], m_d1[t], m_d2[t]));
    endtask

    task automatic reset_pulse();
        reset    = 1'b1;
        op_valid = 1'b0;
        resp_in  = 2'd0;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        logic [1:0] t;
        reset        = 1'b1;
        op_valid     = 1'b0;
        op_cmd       = '0;
        op_data1     = '0;
        op_data2     = '0;
        resp_in      = '0;
        resp_data_in = '0;
        resp_tag_in  = '0;
        res_ready    = 1'b0;
        repeat (3) @(posedge c_clk);
        #1;
        reset = 1'b0;
        @(negedge c_clk);
        chk("reset_timeout_err", timeout_err, 1'b0);
        chk("reset_spurious_err", spurious_err, 1'b0);
        chk("reset_op_tag", op_tag, 2'd0);

        // single op, two request beats, one result
        tick();
        res_ready = 1'b1;
        do_op(4'd1, 32'h5, 32'h7);
        @(negedge c_clk);
        chk("t36_beat1", {req_cmd_out, req_data_out, req_tag_out},
            {4'd1, 32'h5, 2'd0});
        tick();
        @(negedge c_clk);
        chk("t36_beat2", {req_cmd_out, req_data_out, req_tag_out},
            {4'd0, 32'h7, 2'd0});
        tick();
        resp_in      = 2'd1;
        resp_tag_in  = 2'd0;
        resp_data_in = 32'hC;
        exp_q.push_back({2'd1, 32'hC, 2'd0});
        @(negedge c_clk);
        chk("t36_no_bypass", res_valid, 1'b0);
        tick();
        resp_in = 2'd0;
        @(negedge c_clk);
        chk("t36_result", {res_valid, res_resp, res_data, res_tag},
            {1'b1, 2'd1, 32'hC, 2'd0});
        tick();

        // four ops back to back, no responses
        res_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            do_op(4'(i + 2), $urandom, $urandom);
            t_acc[i] = $time;
        end
        for (int i = 1; i < 4; i++)
            chk("t37_spacing", 64'(t_acc[i] - t_acc[i-1]), 64'd20);
        tick();
        tick();
        @(negedge c_clk);
        chk("t37_full_not_ready", op_ready, 1'b0);
        tick();
        respond(2'd2);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        @(negedge c_clk);
        chk("t37_ready_after_pop", {op_ready, op_tag}, {1'b1, 2'd2});
        tick();

        // out-of-order responses buffered, released in arrival order
        do_op(4'd3, $urandom, $urandom);
        respond(2'd3);
        respond(2'd1);
        respond(2'd0);
        respond(2'd2);
        tick();
        @(negedge c_clk);
        chk("t38_buffered", {res_valid, res_tag}, {1'b1, 2'd3});
        tick();
        res_ready = 1'b1;
        repeat (6) tick();
        @(negedge c_clk);
        chk("t38_drained", res_valid, 1'b0);
        chk("t38_results_left", exp_q.size(), 0);
        tick();

        // response for a tag that is not pending
        reset_pulse();
        do_op(4'd1, 32'h10, 32'h20);
        tick();
        tick();
        send_resp(2'd2, 2'd1, 32'hDEAD);
        @(negedge c_clk);
        chk("t39_spurious", {spurious_err, res_valid}, {1'b1, 1'b0});
        tick();
        respond(2'd0);
        repeat (3) tick();
        reset_pulse();

        // watchdog
        do_op(4'd7, $urandom, $urandom);
        repeat (7) @(posedge c_clk);
        @(negedge c_clk);
        chk("t40_timeout_early", timeout_err, 1'b0);
        @(negedge c_clk);
        chk("t40_timeout", timeout_err, 1'b1);
        tick();
        reset_pulse();
        @(negedge c_clk);
        chk("t40_cleared", timeout_err, 1'b0);
        tick();

        // reset during SEND1
        do_op(4'd9, 32'h1234, 32'h5678);
        reset = 1'b1;
        @(negedge c_clk);
        chk("t41_req_in_reset", req_cmd_out, 4'd0);
        tick();
        reset = 1'b0;
        @(negedge c_clk);
        chk("t41_after_reset", {req_cmd_out, op_ready, op_tag},
            {4'd0, 1'b1, 2'd0});
        tick();
        send_resp(2'd0, 2'd1, 32'h99);
        @(negedge c_clk);
        chk("t41_late_resp_spurious", spurious_err, 1'b1);
        tick();
        reset_pulse();

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            reset        = (c % 700 == 350);
            op_valid     = ($urandom_range(0, 2) != 0);
            op_cmd       = 4'($urandom);
            op_data1     = $urandom;
            op_data2     = $urandom;
            res_ready    = ($urandom_range(0, 3) != 0);
            resp_in      = 2'd0;
            resp_tag_in  = 2'($urandom);
            resp_data_in = $urandom;
            if (!reset) begin
                if ($urandom_range(0, 99) == 0) begin
                    resp_in = 2'($urandom_range(1, 3));
                end else if (m_pending != 4'd0 &&
                             $urandom_range(0, 2) == 0) begin
                    t = 2'($urandom);
                    while (!m_pending[t]) t = t + 2'd1;
                    resp_in      = dev_code(m_cmd[t]);
                    resp_tag_in  = t;
                    resp_data_in = dev_data(m_cmd[t], m_d1[t], m_d2[t]);
                end
                if (resp_in != 2'd0 && m_pending[resp_tag_in])
                    exp_q.push_back({resp_in, resp_data_in, resp_tag_in});
            end
            tick();
        end

        // drain
        reset     = 1'b0;
        op_valid  = 1'b0;
        resp_in   = 2'd0;
        res_ready = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (m_pending != 4'd0) respond(lowest_free(~m_pending));
            else tick();
        end
        @(negedge c_clk);
        chk("final_res_valid", res_valid, 1'b0);
        chk("final_results_left", exp_q.size(), 0);
        chk("final_op_ready", op_ready, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
